sti_load_sched: RTL

STI_LOAD_SCHED -- requirements
Module: sti_load_sched

---
 rtl/sti_load_sched_pkg.sv | 31 +++
 rtl/sti_load_sched_if.sv | 26 ++
 rtl/sti_load_sched_rr_arb2.sv | 32 +++
 rtl/sti_load_sched.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sti_load_sched_pkg.sv
// Shared types and constants for the serial-transmitter load scheduler.
package sti_load_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_END   = 3'd3,
        ST_END_LOAD   = 3'd4,
        ST_FINISH     = 3'd5
    } state_t;

    localparam int START_TIMEOUT_DEFAULT = 16;
    localparam int BEAT_COUNT            = 8;

    // cfg word layout: {length[1:0], fill, msb, low}
    localparam int CFG_LEN_HI = 4;
    localparam int CFG_LEN_LO = 3;
    localparam int CFG_FILL   = 2;
    localparam int CFG_MSB    = 1;
    localparam int CFG_LOW    = 0;

    localparam logic [5:0] BEAT_SAT = 6'd63;

    function automatic logic [5:0] expected_beats(input logic [1:0] length);
        logic [5:0] words;
        words = {4'd0, length} + 6'd1;
        return words * 6'(BEAT_COUNT);
    endfunction

endpackage

// File: rtl/sti_load_sched_if.sv
// Requester, transmitter and parallel-load signals of the load scheduler.
interface sti_load_sched_if;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic [4:0]  cfg0, cfg1;
    logic        last0, last1;
    logic        gnt0, gnt1;
    logic        so_valid;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill, pi_msb, pi_low, pi_end;
    logic        busy, done, err;

    modport master (
        output req0, req1, data0, data1, cfg0, cfg1, last0, last1, so_valid,
        input  gnt0, gnt1, load, pi_data, pi_length, pi_fill, pi_msb, pi_low,
               pi_end, busy, done, err
    );

    modport slave (
        input  req0, req1, data0, data1, cfg0, cfg1, last0, last1, so_valid,
        output gnt0, gnt1, load, pi_data, pi_length, pi_fill, pi_msb, pi_low,
               pi_end, busy, done, err
    );
endinterface

// File: rtl/sti_load_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr_r;

    // Grant choice: a lone requester always wins, contention resolved by the pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer update on an accepted grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/sti_load_sched.sv
// Schedules requester words onto a serial transmitter and checks its beat count.
module sti_load_sched
    import sti_load_sched_pkg::*;
#(
    parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    sti_load_sched_if.slave    bus
);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    state_t          state_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [5:0]      beat_cnt_r;
    logic            sv_q_r;
    logic [1:0]      last_seen_r;
    logic [1:0]      gnt_r;
    logic            load_r, pi_end_r, busy_r, done_r, err_r;
    logic [15:0]     pi_data_r;
    logic [1:0]      pi_length_r;
    logic            pi_fill_r, pi_msb_r, pi_low_r;

    logic [1:0]      elig_s;
    logic [1:0]      arb_gnt_s;
    logic            grant_en_s;
    logic            fall_s;
    logic [15:0]     sel_data_s;
    logic [4:0]      sel_cfg_s;

    // Requesters whose final word was accepted drop out of arbitration.
    assign elig_s     = {bus.req1, bus.req0} & ~last_seen_r;
    assign grant_en_s = (state_r == ST_IDLE) && !(&last_seen_r);
    assign fall_s     = sv_q_r && !bus.so_valid;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (elig_s),
        .advance (grant_en_s),
        .gnt     (arb_gnt_s)
    );

    // Word/cfg of the requester the arbiter picked.
    always_comb begin
        if (arb_gnt_s[1]) begin
            sel_data_s = bus.data1;
            sel_cfg_s  = bus.cfg1;
        end else begin
            sel_data_s = bus.data0;
            sel_cfg_s  = bus.cfg0;
        end
    end

    // Registered so_valid for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sv_q_r <= 1'b0;
        end else begin
            sv_q_r <= bus.so_valid;
        end
    end

    // Main sequencer with registered strobes, hold registers and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= '0;
            beat_cnt_r  <= 6'd0;
            last_seen_r <= 2'b00;
            gnt_r       <= 2'b00;
            load_r      <= 1'b0;
            pi_end_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            pi_data_r   <= 16'd0;
            pi_length_r <= 2'd0;
            pi_fill_r   <= 1'b0;
            pi_msb_r    <= 1'b0;
            pi_low_r    <= 1'b0;
        end else begin
            gnt_r    <= 2'b00;
            load_r   <= 1'b0;
            pi_end_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (&last_seen_r) begin
                        state_r   <= ST_END_LOAD;
                        load_r    <= 1'b1;
                        pi_end_r  <= 1'b1;
                        pi_data_r <= 16'd0;
                        busy_r    <= 1'b1;
                    end else if (arb_gnt_s != 2'b00) begin
                        gnt_r       <= arb_gnt_s;
                        pi_data_r   <= sel_data_s;
                        pi_length_r <= sel_cfg_s[CFG_LEN_HI:CFG_LEN_LO];
                        pi_fill_r   <= sel_cfg_s[CFG_FILL];
                        pi_msb_r    <= sel_cfg_s[CFG_MSB];
                        pi_low_r    <= sel_cfg_s[CFG_LOW];
                        last_seen_r <= last_seen_r | (arb_gnt_s & {bus.last1, bus.last0});
                        state_r     <= ST_LOAD;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    load_r    <= 1'b1;
                    tmo_cnt_r <= '0;
                    state_r   <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    // The first valid cycle is already a beat of the word.
                    if (bus.so_valid) begin
                        beat_cnt_r <= 6'd1;
                        state_r    <= ST_WAIT_END;
                    end else if (tmo_cnt_r == TW'(START_TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_WAIT_END: begin
                    if (fall_s) begin
                        if (beat_cnt_r != expected_beats(pi_length_r)) begin
                            err_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bus.so_valid && (beat_cnt_r != BEAT_SAT)) begin
                        beat_cnt_r <= beat_cnt_r + 6'd1;
                    end
                end
                ST_END_LOAD: begin
                    state_r <= ST_FINISH;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                ST_FINISH: begin
                    state_r <= ST_FINISH;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt_r[0];
    assign bus.gnt1      = gnt_r[1];
    assign bus.load      = load_r;
    assign bus.pi_end    = pi_end_r;
    assign bus.pi_data   = pi_data_r;
    assign bus.pi_length = pi_length_r;
    assign bus.pi_fill   = pi_fill_r;
    assign bus.pi_msb    = pi_msb_r;
    assign bus.pi_low    = pi_low_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
endmodule
